// File: rtl/uint_codec_pkg.sv
// -----------------------------------------------------------------------------
// uint_codec_pkg
//   Constants and types shared by the varint encoder and decoder.
//   Encoded words are sequences of 7-bit groups; bit 7 of each byte is the
//   continuation flag. The least-significant group comes first.
// -----------------------------------------------------------------------------
package uint_codec_pkg;

    localparam int GROUP_BITS   = 7;
    localparam int CONT_BIT     = 7;
    localparam int UINT_BITS    = 64;
    localparam int MAX_BYTES    = 10;
    localparam int ENCODED_BITS = MAX_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUTPUT = 2'd2
    } state_e;

endpackage : uint_codec_pkg

// File: rtl/uint_decode.sv
// -----------------------------------------------------------------------------
// uint_decode
//   Varint decoder. It accepts one encoded word (byte k at
//   s_axis_tdata[ENCODED_BITS-1-8k -: 8]), walks it one byte per cycle, and
//   presents the decoded unsigned value plus the number of bytes consumed.
//   One word is in flight at a time: a new word is accepted only once the
//   previous result has been taken downstream.
//
// Ports
//   clk            in   clock
//   aresetn        in   asynchronous active-low reset
//   s_axis_tvalid  in   encoded word valid
//   s_axis_tready  out  decoder can accept a word (idle)
//   s_axis_tdata   in   encoded bytes, first byte in the top byte lane
//   m_axis_tvalid  out  decoded result valid
//   m_axis_tready  in   downstream accepts result
//   m_axis_tdata   out  decoded value
//   m_axis_tuser   out  encoded bytes consumed (1..MAX_BYTES)
//   m_axis_terr    out  malformed-input flag
//
// Build option
//   UINT_DECODE_ERR_EN  when defined, an unterminated word or overflow bits in
//                       the final byte raise m_axis_terr and force the value
//                       to 0. When undefined m_axis_terr stays 0 and the value
//                       is silently truncated.
// -----------------------------------------------------------------------------
module uint_decode
    import uint_codec_pkg::*;
#(
    parameter int UINT_BITS_P    = UINT_BITS,
    parameter int ENCODED_BITS_P = ENCODED_BITS,
    parameter int TUSER_BITS     = $clog2(ENCODED_BITS_P / 2)
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [ENCODED_BITS_P-1:0] s_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [UINT_BITS_P-1:0]    m_axis_tdata,
    output logic [TUSER_BITS-1:0]     m_axis_tuser,
    output logic                      m_axis_terr
);

    localparam int BYTES = ENCODED_BITS_P / 8;
    localparam int IDX_W = $clog2(BYTES + 1);
    // Number of bits of the final group that still land inside the result.
    localparam int LAST_KEEP = UINT_BITS_P - GROUP_BITS * (BYTES - 1);

    state_e                      state_q, state_d;
    logic [ENCODED_BITS_P-1:0]   shift_q, shift_d;
    logic [UINT_BITS_P-1:0]      acc_q, acc_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        ready_q, ready_d;
    logic                        tvalid_q, tvalid_d;
    logic [UINT_BITS_P-1:0]      tdata_q, tdata_d;
    logic [TUSER_BITS-1:0]       tuser_q, tuser_d;
    logic                        terr_q, terr_d;

    logic [7:0]                  cur_byte;
    logic [GROUP_BITS-1:0]       cur_grp;
    logic [UINT_BITS_P-1:0]      placed;
    logic [UINT_BITS_P-1:0]      acc_next;
    logic                        last_byte;
    logic                        err_now;

    // The byte under decode is always the top lane of the shift register.
    assign cur_byte  = shift_q[ENCODED_BITS_P-1 -: 8];
    assign cur_grp   = cur_byte[GROUP_BITS-1:0];
    // Widen first, then shift: group bits pushed past the result width fall off.
    assign placed    = UINT_BITS_P'(cur_grp) << (GROUP_BITS * int'(idx_q));
    assign acc_next  = acc_q | placed;
    assign last_byte = (idx_q == IDX_W'(BYTES - 1));

`ifdef UINT_DECODE_ERR_EN
    logic overflow;
    // Any final-group bit above the ones that fit in the result is overflow.
    assign overflow = |(cur_grp >> LAST_KEEP);
    assign err_now  = last_byte & (cur_byte[CONT_BIT] | overflow);
`else
    assign err_now  = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        terr_d   = terr_q;

        unique case (state_q)
            IDLE: begin
                if (s_axis_tvalid && ready_q) begin
                    shift_d = s_axis_tdata;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                acc_d   = acc_next;
                shift_d = shift_q << 8;
                idx_d   = idx_q + IDX_W'(1);
                if (!cur_byte[CONT_BIT] || last_byte) begin
                    state_d  = OUTPUT;
                    tvalid_d = 1'b1;
                    tdata_d  = err_now ? '0 : acc_next;
                    tuser_d  = TUSER_BITS'(idx_q) + TUSER_BITS'(1);
                    terr_d   = err_now;
                end
            end
            OUTPUT: begin
                if (m_axis_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered ready keeps s_axis_tready low while reset is asserted and
        // for the first cycle after, then tracks "next state is IDLE".
        ready_d = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            ready_q  <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            ready_q  <= ready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            terr_q   <= terr_d;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_terr   = terr_q;

endmodule : uint_decode
